// File: rtl/uart_tx_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_pkg
// Shared definitions for the UART Tx arbiter slice.
//   state_t      : scheduler FSM states
//   BAUD_*       : baud select encoding understood by baud_rateGen
//   next_index() : round-robin successor of a requester index
// -----------------------------------------------------------------------------
package uart_tx_arbiter_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARB,
      CONFIG,
      LAUNCH,
      WAIT_BUSY,
      WAIT_DONE,
      RELEASE
   } state_t;

   localparam logic [1:0] BAUD_2400  = 2'd0;
   localparam logic [1:0] BAUD_4800  = 2'd1;
   localparam logic [1:0] BAUD_9600  = 2'd2;
   localparam logic [1:0] BAUD_19200 = 2'd3;

   // Successor of idx in a ring of n entries, so the requester just served
   // becomes the lowest priority on the next arbitration.
   function automatic int unsigned next_index(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker: selects the first set request at or after
// ptr, wrapping from N_REQ-1 back to 0.
//   req         in  N_REQ       request vector
//   ptr         in  IDX         highest-priority index this round
//   grant       out N_REQ       one-hot grant (all zero when no request)
//   grant_idx   out IDX         binary index of the granted requester
//   grant_valid out 1           at least one request was present
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]         req,
   input  logic [$clog2(N_REQ)-1:0] ptr,
   output logic [N_REQ-1:0]         grant,
   output logic [$clog2(N_REQ)-1:0] grant_idx,
   output logic                     grant_valid
);

   localparam int IDX_W = $clog2(N_REQ);

   int unsigned cand;

   // Scan from the farthest offset down to offset 0 so that the nearest
   // requester at/after ptr is the last one written and therefore wins.
   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      cand        = 0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         cand = (int'(ptr) + k) % N_REQ;
         if (req[cand]) begin
            grant_idx   = IDX_W'(cand);
            grant_valid = 1'b1;
         end
      end
      if (grant_valid) begin
         grant[grant_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin scheduler sharing one UART Tx frame engine and its baud_rateGen
// between N_REQ requesters. A granted requester gets the baud select it asked
// for (with a settle delay only when the select actually changes), one frame
// is launched, and ack pulses when the frame completes or is aborted.
//   clock, reset_n        system clock / async active-low reset
//   req, req_data,        per-requester level request, payload, baud select
//   req_baud
//   gnt, ack, err         one-hot grant, 1-cycle ack, 1-cycle abort flag
//   baud_rate, baud_clk   select to / tick from baud_rateGen
//   tx_send, tx_data      start strobe and payload to the Tx engine
//   tx_busy, tx_done      frame in progress / end-of-stop-bit pulse
// -----------------------------------------------------------------------------
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int N_REQ         = 4,
   parameter int DATA_W        = 8,
   parameter int SETTLE_TICKS  = 2,
   parameter int START_TIMEOUT = 1024
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   input  logic [N_REQ*2-1:0]      req_baud,
   output logic [N_REQ-1:0]        gnt,
   output logic [N_REQ-1:0]        ack,
   output logic                    err,
   output logic [1:0]              baud_rate,
   input  logic                    baud_clk,
   output logic                    tx_send,
   output logic [DATA_W-1:0]       tx_data,
   input  logic                    tx_busy,
   input  logic                    tx_done
);

   localparam int IDX_W  = $clog2(N_REQ);
   localparam int TICK_W = $clog2(SETTLE_TICKS + 1);
   localparam int TO_W   = $clog2(START_TIMEOUT + 1);

   state_t             state;
   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   idx;
   logic               cfg_valid;
   logic               baud_clk_q;
   logic [TICK_W-1:0]  tick_cnt;
   logic [TO_W-1:0]    timeout_cnt;
   logic               err_flag;

   logic [N_REQ-1:0]   arb_grant;
   logic [IDX_W-1:0]   arb_idx;
   logic               arb_valid;
   logic [1:0]         arb_baud;
   logic [DATA_W-1:0]  arb_data;
   logic               baud_edge;

   rr_arbiter #(
      .N_REQ (N_REQ)
   ) u_rr (
      .req         (req),
      .ptr         (rr_ptr),
      .grant       (arb_grant),
      .grant_idx   (arb_idx),
      .grant_valid (arb_valid)
   );

   assign arb_baud  = req_baud[arb_idx*2 +: 2];
   assign arb_data  = req_data[arb_idx*DATA_W +: DATA_W];
   assign baud_edge = baud_clk & ~baud_clk_q;

   // Scheduler FSM with all outputs registered. tx_send, ack and err default
   // low every cycle so each is a single-cycle pulse. cfg_valid records that
   // baud_rateGen has settled on the current baud_rate, letting a requester
   // with the same select skip CONFIG; a start timeout clears it because the
   // Tx side is then in an unknown condition.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         gnt         <= '0;
         ack         <= '0;
         err         <= 1'b0;
         tx_send     <= 1'b0;
         tx_data     <= '0;
         baud_rate   <= BAUD_2400;
         rr_ptr      <= '0;
         idx         <= '0;
         cfg_valid   <= 1'b0;
         baud_clk_q  <= 1'b0;
         tick_cnt    <= '0;
         timeout_cnt <= '0;
         err_flag    <= 1'b0;
      end else begin
         baud_clk_q <= baud_clk;
         tx_send    <= 1'b0;
         ack        <= '0;
         err        <= 1'b0;
         case (state)
            IDLE: begin
               if (|req) begin
                  state <= ARB;
               end
            end
            ARB: begin
               // A request withdrawn before arbitration simply returns to IDLE.
               if (arb_valid) begin
                  idx      <= arb_idx;
                  gnt      <= arb_grant;
                  tx_data  <= arb_data;
                  err_flag <= 1'b0;
                  if (cfg_valid && (arb_baud == baud_rate)) begin
                     tx_send <= 1'b1;
                     state   <= LAUNCH;
                  end else begin
                     baud_rate <= arb_baud;
                     tick_cnt  <= '0;
                     state     <= CONFIG;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            CONFIG: begin
               if (baud_edge) begin
                  if (tick_cnt == TICK_W'(SETTLE_TICKS - 1)) begin
                     cfg_valid <= 1'b1;
                     tx_send   <= 1'b1;
                     state     <= LAUNCH;
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end
            LAUNCH: begin
               timeout_cnt <= '0;
               state       <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               if (tx_busy) begin
                  state <= WAIT_DONE;
               end else if (timeout_cnt == TO_W'(START_TIMEOUT)) begin
                  err_flag  <= 1'b1;
                  cfg_valid <= 1'b0;
                  state     <= RELEASE;
               end else begin
                  timeout_cnt <= timeout_cnt + 1'b1;
               end
            end
            WAIT_DONE: begin
               if (tx_done) begin
                  state <= RELEASE;
               end
            end
            RELEASE: begin
               ack[idx] <= 1'b1;
               err      <= err_flag;
               gnt      <= '0;
               rr_ptr   <= IDX_W'(next_index(int'(idx), N_REQ));
               state    <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
